thirty_seven_bit_full_adder: RTL and testbench

THIRTY_SEVEN_BIT_FULL_ADDER -- requirements
Module: thirty_seven_bit_full_adder

---
 rtl/thirty_seven_bit_full_adder_pkg.sv | 8 +
 rtl/full_adder_bit.sv | 13 +
 rtl/thirty_seven_bit_full_adder.sv | 41 ++++
 tb/tb_thirty_seven_bit_full_adder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/thirty_seven_bit_full_adder_pkg.sv
// Shared widths for the 37-bit registered ripple-carry adder.
package thirty_seven_bit_full_adder_pkg;

  localparam int unsigned Width       = 37;
  // Sum bits plus the carry-out bit.
  localparam int unsigned ResultWidth = Width + 1;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell used as the ripple-chain element.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/thirty_seven_bit_full_adder.sv
// Registered ripple-carry adder: {c_out, sum} <= a + b + c_in, one-cycle latency.
module thirty_seven_bit_full_adder
  import thirty_seven_bit_full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = Width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_bit u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum_d[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= sum_d;
      c_out <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_thirty_seven_bit_full_adder.sv
// Scoreboard bench for thirty_seven_bit_full_adder against a 38-bit golden sum.
module tb_thirty_seven_bit_full_adder;
  import thirty_seven_bit_full_adder_pkg::*;

  typedef struct {
    logic [ResultWidth-1:0] exp;
    logic [Width-1:0]       a;
    logic [Width-1:0]       b;
    logic                   c_in;
    int                     idx;
    string                  name;
  } sb_entry_t;

  logic             clk;
  logic             rst_n;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             c_in;
  logic [Width-1:0] sum;
  logic             c_out;

  sb_entry_t sb[$];
  sb_entry_t ent;
  int checks = 0;
  int passed = 0;

  localparam logic [Width-1:0] AllOnes = {Width{1'b1}};

  thirty_seven_bit_full_adder #(.WIDTH(Width)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ResultWidth-1:0] golden(input logic [Width-1:0] ga,
                                                   input logic [Width-1:0] gb,
                                                   input logic gc, input logic grst_n);
    logic [ResultWidth-1:0] r;
    r = {1'b0, ga} + {1'b0, gb} + {{(ResultWidth-1){1'b0}}, gc};
    return grst_n ? r : '0;
  endfunction

  // Drive one input set (called just after a falling edge) and queue its expected result.
  task automatic drive(input logic [Width-1:0] da, input logic [Width-1:0] db,
                       input logic dc, input logic drst_n, input string nm, input int id);
    sb_entry_t e;
    a = da; b = db; c_in = dc; rst_n = drst_n;
    e.exp = golden(da, db, dc, drst_n);
    e.a = da; e.b = db; e.c_in = dc; e.idx = id; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(AllOnes, 37'h0A_5A5A_5A5A, 1'b1, 1'b0, "reset", i);
      @(negedge clk);
      ent = sb.pop_front();
      checks++;
      if ({c_out, sum} !== ent.exp) begin
        $display("FAIL %s idx=%0d got=0x%0h want=0x%0h", ent.name, ent.idx,
                 {c_out, sum}, ent.exp);
      end else passed++;
    end
  endtask

  task automatic test_directed();
    logic [Width-1:0] va[4];
    logic [Width-1:0] vb[4];
    logic             vc[4];
    va[0] = '0;              vb[0] = '0;              vc[0] = 1'b0;
    va[1] = AllOnes;         vb[1] = '0;              vc[1] = 1'b1;
    va[2] = AllOnes;         vb[2] = AllOnes;         vc[2] = 1'b1;
    va[3] = 37'h02_3456_789A; vb[3] = 37'h0F_EDCB_A987; vc[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(va[i], vb[i], vc[i], 1'b1, "directed", i);
      @(negedge clk);
      ent = sb.pop_front();
      checks++;
      if ({c_out, sum} !== ent.exp) begin
        $display("FAIL %s idx=%0d a=0x%0h b=0x%0h c_in=%0b got=0x%0h want=0x%0h",
                 ent.name, ent.idx, ent.a, ent.b, ent.c_in, {c_out, sum}, ent.exp);
      end else passed++;
    end
    // Hand-derived values for the mixed-operand case, independent of the model.
    checks++;
    if (sum !== 37'h12_2222_2222 || c_out !== 1'b0) begin
      $display("FAIL mixed_const got=0x%0h/%0b want=0x1222222222/0", sum, c_out);
    end else passed++;
  endtask

  // Back-to-back pipeline: compare the previous edge's result while driving the next.
  task automatic test_reset_midstream();
    @(negedge clk);
    drive(37'h13_5555_0001, 37'h07_0F0F_F0F0, 1'b1, 1'b1, "midstream", 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      ent = sb.pop_front();
      checks++;
      if ({c_out, sum} !== ent.exp) begin
        $display("FAIL %s idx=%0d a=0x%0h b=0x%0h c_in=%0b got=0x%0h want=0x%0h",
                 ent.name, ent.idx, ent.a, ent.b, ent.c_in, {c_out, sum}, ent.exp);
      end else passed++;
      if (i == 1) drive(AllOnes, AllOnes, 1'b1, 1'b0, "midstream", i);
      else if (i == 2) drive(37'h1F_0000_0001, 37'h01_0000_0000, 1'b0, 1'b1, "midstream", i);
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [63:0]      r1;
    logic [63:0]      r2;
    logic [Width-1:0] ra;
    logic [Width-1:0] rb;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        ent = sb.pop_front();
        checks++;
        if ({c_out, sum} !== ent.exp) begin
          $display("FAIL %s idx=%0d a=0x%0h b=0x%0h c_in=%0b got=0x%0h want=0x%0h",
                   ent.name, ent.idx, ent.a, ent.b, ent.c_in, {c_out, sum}, ent.exp);
        end else passed++;
      end
      if (i < n) begin
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        ra = r1[Width-1:0];
        rb = r2[Width-1:0];
        // Bias some vectors toward full-length carry chains.
        if ($urandom_range(0, 7) == 0) ra = AllOnes;
        if ($urandom_range(0, 7) == 0) rb = ~ra;
        drive(ra, rb, 1'($urandom_range(0, 1)), 1'b1, "random", i);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    test_reset();
    test_directed();
    test_reset_midstream();
    test_back_to_back(20000);
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
